// File: rtl/pl_rf_pkg.sv
// Shared widths and types for the multi-port pipeline register file.
package pl_rf_pkg;
  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/pl_reg_file_mp_if.sv
// Decode/WB-side bundle of the multi-port register file.
// The master is the pipeline and the slave is the register file.
interface pl_reg_file_mp_if
  import pl_rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);
  logic                           enable;
  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
  logic [NUM_RD-1:0]              rd_busy;
  logic [NUM_WR-1:0]              wr_en;
  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data;
  logic                           busy_set;
  logic [ADDR_W-1:0]              busy_addr;
  logic                           any_busy;

  modport master (
    output enable, rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  enable, rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
    output rd_data, rd_busy, any_busy
  );
endinterface

// File: rtl/pl_reg_file_mp_bypass_mux.sv
// Per-read-port forwarding match: the highest-index enabled write to the read
// address wins and is returned with a hit flag.
module pl_rf_bypass_mux
  import pl_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                          i_enable,
  input  logic [NUM_WR-1:0]             i_wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  output logic                          o_hit,
  output logic [DATA_W-1:0]             o_data
);
  logic w_zero;

  always_comb begin
    w_zero = (ZERO_REG != 0) && (i_rd_addr == '0);
    o_hit  = 1'b0;
    o_data = '0;
    // Ascending scan so the later (higher-index) port overrides earlier hits.
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (i_enable && i_wr_en[k] && (i_wr_addr[k] == i_rd_addr) && !w_zero) begin
        o_hit  = 1'b1;
        o_data = i_wr_data[k];
      end
    end
  end
endmodule

// File: rtl/pl_reg_file_mp.sv
// Multi-port ID-stage register file with write-to-read bypass, optional
// hardwired zero register and a per-register busy scoreboard.
module pl_reg_file_mp
  import pl_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input logic            clk,
  input logic            reset,
  pl_reg_file_mp_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("pl_reg_file_mp: NUM_RD must be 1..4");
  end
  if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
    $error("pl_reg_file_mp: NUM_WR must be 1..2");
  end

  logic [DATA_W-1:0]             r_mem [DEPTH];
  logic [DEPTH-1:0]              r_busy;
  logic [DEPTH-1:0]              w_busy_next;
  logic [NUM_WR-1:0]             w_commit;
  logic [NUM_RD-1:0]             w_hit;
  logic [NUM_RD-1:0][DATA_W-1:0] w_byp_data;

  always_comb begin
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      w_commit[k] = bus.enable && bus.wr_en[k] &&
                    !((ZERO_REG != 0) && (bus.wr_addr[k] == '0));
    end
  end

  // Same-address writes: the later loop iteration's NBA wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (w_commit[k]) begin
          r_mem[bus.wr_addr[k]] <= bus.wr_data[k];
        end
      end
    end
  end

  // Clears applied before the set so a new producer overrides the completing one.
  always_comb begin
    w_busy_next = r_busy;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (w_commit[k]) begin
        w_busy_next[bus.wr_addr[k]] = 1'b0;
      end
    end
    if (bus.busy_set && !((ZERO_REG != 0) && (bus.busy_addr == '0))) begin
      w_busy_next[bus.busy_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else if (bus.enable) begin
      r_busy <= w_busy_next;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    pl_rf_bypass_mux #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_byp (
      .i_enable  (bus.enable),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .i_rd_addr (bus.rd_addr[p]),
      .o_hit     (w_hit[p]),
      .o_data    (w_byp_data[p])
    );
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if ((ZERO_REG != 0) && (bus.rd_addr[p] == '0)) begin
        bus.rd_data[p] = '0;
        bus.rd_busy[p] = 1'b0;
      end else begin
        bus.rd_data[p] = w_hit[p] ? w_byp_data[p] : r_mem[bus.rd_addr[p]];
        bus.rd_busy[p] = r_busy[bus.rd_addr[p]] && !w_hit[p];
      end
    end
    bus.any_busy = |r_busy;
  end
endmodule

// File: tb/tb_pl_reg_file_mp.sv
// Self-checking bench for pl_reg_file_mp: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_pl_reg_file_mp;
  import pl_rf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pl_reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();

  pl_reg_file_mp #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .ZERO_REG (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit fwd_hit(input rf_addr_t a);
    bit h = 0;
    if (a == 0 || !bus.enable) return 0;
    for (int k = 0; k < 2; k++)
      if (bus.wr_en[k] && bus.wr_addr[k] == a) h = 1;
    return h;
  endfunction

  function automatic logic [31:0] exp_read(input rf_addr_t a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_mem[a];
    if (bus.enable)
      for (int k = 0; k < 2; k++)
        if (bus.wr_en[k] && bus.wr_addr[k] == a) v = bus.wr_data[k];
    return v;
  endfunction

  function automatic bit exp_busy(input rf_addr_t a);
    if (a == 0) return 0;
    return m_busy[a] && !fwd_hit(a);
  endfunction

  function automatic bit exp_any();
    bit b = 0;
    foreach (m_busy[i]) b |= m_busy[i];
    return b;
  endfunction

  task automatic model_edge();
    if (reset) begin
      foreach (m_mem[i]) begin
        m_mem[i]  = '0;
        m_busy[i] = 0;
      end
    end else if (bus.enable) begin
      for (int k = 0; k < 2; k++)
        if (bus.wr_en[k] && bus.wr_addr[k] != 0) begin
          m_mem[bus.wr_addr[k]]  = bus.wr_data[k];
          m_busy[bus.wr_addr[k]] = 0;
        end
      if (bus.busy_set && bus.busy_addr != 0) m_busy[bus.busy_addr] = 1;
    end
  endtask

  task automatic check_model(input string pfx);
    #2;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s_rd_data%0d", pfx, p), bus.rd_data[p], exp_read(bus.rd_addr[p]));
      check($sformatf("%s_rd_busy%0d", pfx, p), bus.rd_busy[p], exp_busy(bus.rd_addr[p]));
    end
    check($sformatf("%s_any_busy", pfx), bus.any_busy, exp_any());
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    reset         = 1'b0;
    bus.enable    = 1'b1;
    bus.wr_en     = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.busy_set  = 1'b0;
    bus.busy_addr = '0;
  endtask

  initial begin
    set_idle();
    reset       = 1'b1;
    bus.rd_addr = '0;
    clock_edge();

    // 1: reset state on every address, both ports
    set_idle();
    bus.enable = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr[0] = 5'(a);
      bus.rd_addr[1] = 5'(31 - a);
      #1;
      check("t1_data0", bus.rd_data[0], 32'h0);
      check("t1_data1", bus.rd_data[1], 32'h0);
      check("t1_busy", {bus.rd_busy, bus.any_busy}, 3'b000);
    end

    // 2: dual write same address, port 1 wins in bypass and storage
    set_idle();
    bus.wr_en   = 2'b11;
    bus.wr_addr[0] = 5'd5; bus.wr_data[0] = 32'hDEADBEEF;
    bus.wr_addr[1] = 5'd5; bus.wr_data[1] = 32'h12345678;
    bus.rd_addr[0] = 5'd5; bus.rd_addr[1] = 5'd0;
    check_model("t2a");
    check("t2_bypass", bus.rd_data[0], 32'h12345678);
    clock_edge();
    set_idle();
    check_model("t2b");
    check("t2_stored", bus.rd_data[0], 32'h12345678);
    clock_edge();

    // 3: register 0 ignores writes and busy_set
    set_idle();
    bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd0; bus.wr_data[0] = 32'hFFFFFFFF;
    bus.busy_set = 1'b1; bus.busy_addr = 5'd0;
    bus.rd_addr[0] = 5'd0; bus.rd_addr[1] = 5'd0;
    check_model("t3a");
    check("t3_data", bus.rd_data[0], 32'h0);
    clock_edge();
    set_idle();
    check_model("t3b");
    check("t3_any", bus.any_busy, 1'b0);
    clock_edge();

    // 4: scoreboard set, hold while idle, clear on completing write
    set_idle();
    bus.busy_set = 1'b1; bus.busy_addr = 5'd7;
    bus.rd_addr[0] = 5'd7; bus.rd_addr[1] = 5'd7;
    check_model("t4set");
    clock_edge();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      check_model("t4idle");
      check("t4_busy_idle", bus.rd_busy[0], 1'b1);
      check("t4_any_idle", bus.any_busy, 1'b1);
      clock_edge();
    end
    set_idle();
    bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd7; bus.wr_data[0] = 32'hA5A5A5A5;
    check_model("t4wr");
    check("t4_busy_wr", bus.rd_busy[0], 1'b0);
    check("t4_data_wr", bus.rd_data[0], 32'hA5A5A5A5);
    clock_edge();
    set_idle();
    check_model("t4after");
    check("t4_any_after", bus.any_busy, 1'b0);
    clock_edge();

    // 5: stalled write is neither forwarded nor committed
    set_idle();
    bus.enable = 1'b0;
    bus.wr_en = 2'b01; bus.wr_addr[0] = 5'd3; bus.wr_data[0] = 32'h55;
    bus.rd_addr[0] = 5'd3;
    check_model("t5stall");
    check("t5_nobyp", bus.rd_data[0], 32'h0);
    clock_edge();
    set_idle();
    check_model("t5reread");
    check("t5_nocommit", bus.rd_data[0], 32'h0);
    clock_edge();

    // 6: reset dominates pending write and busy bit
    set_idle();
    bus.busy_set = 1'b1; bus.busy_addr = 5'd9;
    bus.rd_addr[0] = 5'd9;
    clock_edge();
    set_idle();
    reset = 1'b1;
    bus.wr_en = 2'b10; bus.wr_addr[1] = 5'd9; bus.wr_data[1] = 32'hCAFEF00D;
    clock_edge();
    set_idle();
    check_model("t6");
    check("t6_data", bus.rd_data[0], 32'h0);
    check("t6_busy", {bus.rd_busy[0], bus.any_busy}, 2'b00);

    // Randomized traffic; narrow address range most of the time for collisions
    for (int c = 0; c < 600; c++) begin
      reset         = ($urandom_range(0, 49) == 0);
      bus.enable    = ($urandom_range(0, 4) != 0);
      bus.wr_en     = 2'($urandom);
      bus.busy_set  = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 2; k++) begin
        bus.wr_addr[k] = 5'($urandom_range(0, 7));
        bus.wr_data[k] = $urandom;
      end
      bus.busy_addr = 5'($urandom_range(0, 7));
      for (int p = 0; p < 2; p++)
        bus.rd_addr[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      check_model("rnd");
      clock_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
